// File: rtl/nanorv32_ahb_arbiter.sv
// nanorv32_ahb_arbiter: shares one AHB-lite slave between the I-fetch and D masters
module nanorv32_ahb_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] haddri,
  input  logic [1:0]        htransi,
  output logic              hreadyi,
  output logic [DATA_W-1:0] hrdatai,
  input  logic [ADDR_W-1:0] haddrd,
  input  logic [1:0]        htransd,
  input  logic              hwrited,
  input  logic [2:0]        hsized,
  input  logic [DATA_W-1:0] hwdatad,
  output logic              hreadyd,
  output logic [DATA_W-1:0] hrdatad,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic [DATA_W-1:0] hrdata
);
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} own_t;
  own_t              r_dph_own;
  logic              r_pend_v;
  logic              r_pend_m;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_pend_write;
  logic [2:0]        r_pend_size;
  logic              r_last_d;
  logic              w_req_i;
  logic              w_req_d;
  logic              w_cap_i;
  logic              w_cap_d;
  own_t              w_aph;
  logic              w_unused;
  // SEQ is treated as NONSEQ, so only htrans[1] matters
  assign w_unused = htransi[0] ^ htransd[0];
  always_comb begin
    w_req_i = htransi[1] & ~(r_pend_v & ~r_pend_m);
    w_req_d = htransd[1] & ~(r_pend_v & r_pend_m);
    w_aph = r_pend_v ? (r_pend_m ? OWN_D : OWN_I) :
            (w_req_i & w_req_d) ? ((DATA_PRIO || !r_last_d) ? OWN_D : OWN_I) :
            w_req_i ? OWN_I :
            w_req_d ? OWN_D : OWN_NONE;
    w_cap_i = (r_dph_own == OWN_I) & w_req_i & (w_aph != OWN_I);
    w_cap_d = (r_dph_own == OWN_D) & w_req_d & (w_aph != OWN_D);
  end
  assign htrans  = (w_aph == OWN_NONE) ? 2'b00 : 2'b10;
  assign haddr   = r_pend_v ? r_pend_addr : (w_aph == OWN_I) ? haddri : haddrd;
  assign hwrite  = r_pend_v ? r_pend_write : (w_aph != OWN_I) & hwrited;
  assign hsize   = r_pend_v ? r_pend_size : (w_aph == OWN_I) ? 3'b010 : hsized;
  assign hwdata  = (r_dph_own == OWN_D) ? hwdatad : '0;
  assign hrdatai = hrdata;
  assign hrdatad = hrdata;
  // a master that just finished its data phase is always released; a captured request completes later
  assign hreadyi = (r_dph_own == OWN_I) ? hready :
                   hready & ~((r_pend_v & ~r_pend_m) | (w_req_i & (w_aph != OWN_I)));
  assign hreadyd = (r_dph_own == OWN_D) ? hready :
                   hready & ~((r_pend_v & r_pend_m) | (w_req_d & (w_aph != OWN_D)));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dph_own    <= OWN_NONE;
      r_pend_v     <= 1'b0;
      r_pend_m     <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_write <= 1'b0;
      r_pend_size  <= 3'b000;
      r_last_d     <= 1'b0;
    end else if (hready) begin
      r_dph_own <= w_aph;
      if (w_aph != OWN_NONE) r_last_d <= (w_aph == OWN_D);
      r_pend_v <= w_cap_i | w_cap_d;
      if (w_cap_i | w_cap_d) begin
        r_pend_m     <= w_cap_d;
        r_pend_addr  <= w_cap_d ? haddrd : haddri;
        r_pend_write <= w_cap_d & hwrited;
        r_pend_size  <= w_cap_d ? hsized : 3'b010;
      end
    end
  end
endmodule

// File: tb/tb_nanorv32_ahb_arbiter.sv
// tb_nanorv32_ahb_arbiter: directed vectors against a fixed-priority and a round-robin instance
module tb_nanorv32_ahb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] haddri, haddrd, hwdatad, hrdata;
  logic [1:0]  htransi, htransd;
  logic        hwrited, hready;
  logic [2:0]  hsized;
  logic        a_ri, a_rd, a_hwrite, b_ri, b_rd, b_hwrite;
  logic [31:0] a_rdi, a_rdd, a_haddr, a_hwdata, b_rdi, b_rdd, b_haddr, b_hwdata;
  logic [1:0]  a_htrans, b_htrans;
  logic [2:0]  a_hsize, b_hsize;
  nanorv32_ahb_arbiter #(.DATA_PRIO(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .haddri(haddri), .htransi(htransi), .hreadyi(a_ri), .hrdatai(a_rdi),
    .haddrd(haddrd), .htransd(htransd), .hwrited(hwrited), .hsized(hsized), .hwdatad(hwdatad),
    .hreadyd(a_rd), .hrdatad(a_rdd), .haddr(a_haddr), .htrans(a_htrans), .hwrite(a_hwrite),
    .hsize(a_hsize), .hwdata(a_hwdata), .hready(hready), .hrdata(hrdata));
  nanorv32_ahb_arbiter #(.DATA_PRIO(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .haddri(haddri), .htransi(htransi), .hreadyi(b_ri), .hrdatai(b_rdi),
    .haddrd(haddrd), .htransd(htransd), .hwrited(hwrited), .hsized(hsized), .hwdatad(hwdatad),
    .hreadyd(b_rd), .hrdatad(b_rdd), .haddr(b_haddr), .htrans(b_htrans), .hwrite(b_hwrite),
    .hsize(b_hsize), .hwdata(b_hwdata), .hready(hready), .hrdata(hrdata));
  typedef struct {
    string       name;
    bit          p;
    logic [1:0]  tr;
    logic [31:0] ad;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        ri;
    logic        rd;
    logic [31:0] rdat;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [135:0] got, want;
  int n_vec = 0;
  int n_bad = 0;
  task automatic idle();
    htransi = 2'b00; haddri = '0; htransd = 2'b00; haddrd = '0; hwrited = 1'b0;
    hsized = 3'b000; hwdatad = '0; hready = 1'b1; hrdata = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
  endtask
  // p=1 selects the DATA_PRIO=1 instance, p=0 the round-robin one
  task automatic push_exp(input string name, input bit p, input logic [1:0] tr, input logic [31:0] ad,
                          input logic wr, input logic [2:0] sz, input logic [31:0] wd,
                          input logic ri, input logic rd);
    exp_t x;
    x.name = name; x.p = p; x.tr = tr; x.ad = ad; x.wr = wr; x.sz = sz; x.wd = wd;
    x.ri = ri; x.rd = rd; x.rdat = hrdata;
    q.push_back(x);
  endtask
  initial forever begin
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      got = e.p ? {a_htrans, a_haddr, a_hwrite, a_hsize, a_hwdata, a_ri, a_rd, a_rdi, a_rdd}
                : {b_htrans, b_haddr, b_hwrite, b_hsize, b_hwdata, b_ri, b_rd, b_rdi, b_rdd};
      want = {e.tr, e.ad, e.wr, e.sz, e.wd, e.ri, e.rd, e.rdat, e.rdat};
      n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s: {htrans,haddr,hwrite,hsize,hwdata,hreadyi,hreadyd,hrdatai,hrdatad} got %h required %h",
                 e.name, got, want);
      end
    end
  end
  logic [31:0] t3_ia[9] = '{32'h200, 32'h200, 32'h204, 32'h208, 32'h208, 32'h20C, 32'h20C, 0, 0};
  logic [31:0] t3_da[9] = '{32'h8000_0100, 32'h8000_0104, 32'h8000_0108, 32'h8000_0108,
                            32'h8000_010C, 32'h8000_010C, 0, 0, 0};
  logic [31:0] t3_ea[9] = '{32'h8000_0100, 32'h200, 32'h8000_0104, 32'h204, 32'h8000_0108,
                            32'h208, 32'h8000_010C, 32'h20C, 0};
  logic [8:0]  t3_ri = 9'b1_0101_0110;
  logic [8:0]  t3_rd = 9'b1_1010_1011;
  initial begin
    idle();
    repeat (2) step();
    rst_n = 1'b1;
    push_exp("reset", 1, 2'b00, 0, 0, 3'd0, 0, 1, 1); step();
    do_reset();
    htransi = 2'b10; haddri = 32'h0; hrdata = 32'h1111_1111;
    push_exp("t1_fetch0", 1, 2'b10, 32'h0, 0, 3'd2, 0, 1, 1); step();
    haddri = 32'h4; hrdata = 32'hA000_0000;
    push_exp("t1_fetch4", 1, 2'b10, 32'h4, 0, 3'd2, 0, 1, 1); step();
    htransi = 2'b00; haddri = 32'h0; hrdata = 32'hA000_0004;
    push_exp("t1_data4", 1, 2'b00, 32'h0, 0, 3'd0, 0, 1, 1); step();
    do_reset();
    htransi = 2'b10; haddri = 32'h100; htransd = 2'b10; haddrd = 32'h8000_0000; hsized = 3'd2;
    push_exp("t2_conflict", 1, 2'b10, 32'h8000_0000, 0, 3'd2, 0, 0, 1); step();
    htransd = 2'b00; haddrd = 0; hsized = 3'd0; hrdata = 32'hD0D0_D0D0;
    push_exp("t2_i_next", 1, 2'b10, 32'h100, 0, 3'd2, 0, 1, 1); step();
    htransi = 2'b00; haddri = 0; hrdata = 32'h1234_5678;
    push_exp("t2_idle", 1, 2'b00, 32'h0, 0, 3'd0, 0, 1, 1); step();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      htransi = (c < 7) ? 2'b10 : 2'b00; haddri = t3_ia[c];
      htransd = (c < 6) ? 2'b10 : 2'b00; haddrd = t3_da[c];
      hsized = (c < 6) ? 3'd2 : 3'd0;
      push_exp($sformatf("t3_c%0d", c + 1), 0, (c < 8) ? 2'b10 : 2'b00, t3_ea[c], 0,
               (c < 8) ? 3'd2 : 3'd0, 0, t3_ri[c], t3_rd[c]);
      step();
    end
    do_reset();
    htransd = 2'b10; haddrd = 32'h8000_0004; hwrited = 1; hsized = 3'd2;
    push_exp("t4_wr_addr", 0, 2'b10, 32'h8000_0004, 1, 3'd2, 0, 1, 1); step();
    haddrd = 32'h8000_0008; hwrited = 0; hwdatad = 32'hCAFF_E000; htransi = 2'b10; haddri = 32'h300;
    push_exp("t4_wr_data", 0, 2'b10, 32'h300, 0, 3'd2, 32'hCAFF_E000, 1, 1); step();
    htransd = 2'b00; haddrd = 0; hsized = 3'd0; hwdatad = 32'h1234_5678; htransi = 2'b00; haddri = 0;
    push_exp("t4_pend_issue", 0, 2'b10, 32'h8000_0008, 0, 3'd2, 0, 1, 0); step();
    hwdatad = 0; hrdata = 32'h5555_AAAA;
    push_exp("t4_pend_data", 0, 2'b00, 32'h0, 0, 3'd0, 0, 1, 1); step();
    do_reset();
    htransd = 2'b10; haddrd = 32'h8000_0010; hsized = 3'd2;
    push_exp("t5_d_addr", 1, 2'b10, 32'h8000_0010, 0, 3'd2, 0, 1, 1); step();
    htransd = 2'b00; haddrd = 0; hsized = 3'd0; htransi = 2'b10; haddri = 32'h400; hready = 0;
    for (int k = 0; k < 3; k++) begin
      push_exp($sformatf("t5_wait%0d", k), 1, 2'b10, 32'h400, 0, 3'd2, 0, 0, 0);
      step();
    end
    hready = 1; hrdata = 32'hBEEF_0010;
    push_exp("t5_resume", 1, 2'b10, 32'h400, 0, 3'd2, 0, 1, 1); step();
    htransi = 2'b00; haddri = 0; hrdata = 32'h4000_4000;
    push_exp("t5_i_data", 1, 2'b00, 32'h0, 0, 3'd0, 0, 1, 1); step();
    do_reset();
    htransd = 2'b10; haddrd = 32'h8000_0004; hwrited = 1; hsized = 3'd2;
    push_exp("t6_wr_addr", 0, 2'b10, 32'h8000_0004, 1, 3'd2, 0, 1, 1); step();
    haddrd = 32'h8000_0008; hwrited = 0; hwdatad = 32'hCAFF_E000; htransi = 2'b10; haddri = 32'h300;
    push_exp("t6_capture", 0, 2'b10, 32'h300, 0, 3'd2, 32'hCAFF_E000, 1, 1); step();
    idle();
    rst_n = 1'b0;
    push_exp("t6_async_rst", 0, 2'b00, 32'h0, 0, 3'd0, 0, 1, 1); step();
    rst_n = 1'b1;
    push_exp("t6_after_rst", 0, 2'b00, 32'h0, 0, 3'd0, 0, 1, 1); step();
    step();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expected vectors never compared, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/nanorv32_ahb_arbiter.md
Name: nanorv32_ahb_arbiter

Overview:
- Two-master to one-slave AHB-lite arbiter for the nanorv32 core.
- Shares one memory/bus slave port between the CPU instruction-fetch master (I) and the CPU data master (D).
- Used when the simpleahb chip maps code and data onto a single RAM port.
- Handles single transfers only: SEQ is forwarded as NONSEQ, and bursts are not preserved across interleaving.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
DATA_PRIO, 1, 1 = fixed priority to D on conflict; 0 = round-robin

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
haddri  in  ADDR_W  I-master address
htransi  in  2  I-master transfer type
hreadyi  out  1  I-master ready
hrdatai  out  DATA_W  I-master read data
haddrd  in  ADDR_W  D-master address
htransd  in  2  D-master transfer type
hwrited  in  1  D-master write
hsized  in  3  D-master size
hwdatad  in  DATA_W  D-master write data
hreadyd  out  1  D-master ready
hrdatad  out  DATA_W  D-master read data
haddr  out  ADDR_W  slave address
htrans  out  2  slave transfer type
hwrite  out  1  slave write
hsize  out  3  slave size
hwdata  out  DATA_W  slave write data
hready  in  1  slave ready
hrdata  in  DATA_W  slave read data

Behaviour:
- Interface: clock clk; reset rst_n, asynchronous, active-low.
- State registers:
  - dph_own: data-phase owner, one of NONE/I/D.
  - Pending buffer: pend_v, pend_m, pend_addr, pend_write, pend_size.
  - last_g: last-granted master, for round-robin.
- Reset values: dph_own=NONE, pend_v=0, last_g=I.
- Outputs directly after reset: htrans=IDLE unless a master requests; hreadyi=hreadyd=hready.
- Live request:
  - req_x = htrans_x[1] & ~(pend_v & pend_m==x).
  - The I master always reads: hwrite=0, hsize=3'b010.
- Arbitration (combinational, address-phase owner aph):
  - If pend_v, aph=pend_m.
  - Else if exactly one req_x, aph=x.
  - Else if both request: DATA_PRIO=1 → D; DATA_PRIO=0 → the master that is not last_g.
  - Else aph=NONE.
- Slave address-phase outputs:
  - aph=NONE: htrans=2'b00; haddr/hwrite/hsize driven from D inputs, don't-care.
  - Otherwise: htrans=2'b10, with addr/ctrl taken from the pend_* registers when pend_v, else from the live inputs of aph.
- On hready=1 (clock edge):
  - dph_own<=aph.
  - last_g<=aph if aph!=NONE.
  - pend_v<=0 if pend_v was consumed.
- Capture:
  - Trigger: hready=1, dph_own==x, req_x=1, aph!=x.
  - Action: pend_v<=1, pend_m<=x, latch x's addr/write/size.
  - Master x sees ready=1; its transfer is accepted and completes later.
  - At most one pending entry exists.
  - A pending entry always wins the next hready=1 cycle.
- Master ready, hready_x:
  - Equals hready if dph_own==x.
  - Else 0 if (pend_v & pend_m==x), meaning the transfer is still waiting.
  - Else 0 if req_x & aph!=x (lost arbitration; the master holds its address).
  - Else hready.
- Data path:
  - hwdata = hwdatad when dph_own==D, else 0.
  - hrdatai = hrdatad = hrdata (broadcast).
- Latency:
  - Uncontended transfer: same as a direct slave connection.
  - Losing master: stalled exactly one slave-accepted transfer per contention with round-robin.
  - With DATA_PRIO=1, I can starve under continuous D traffic; this is accepted.
- hready=0: no state changes; all address-phase outputs stay stable because masters hold and pend_* is frozen.
- Reset mid-transfer: pending entry and dph_own are discarded immediately; no completion is signalled.

Test Plan:
1. Reset, I fetches 0x0, 0x4, D idle, slave hready=1 → htrans=10, haddr=0x0 then 0x4; hreadyi=1 every cycle; hrdatai equals slave data one cycle later.
2. DATA_PRIO=1, I and D both NONSEQ (I 0x100, D read 0x8000_0000) same cycle → slave sees D address first; hreadyi=0 one cycle; I address 0x100 issued next cycle.
3. DATA_PRIO=0, both request continuously for 6 cycles → slave addresses alternate I,D,I,D,I,D after first grant; last_g toggles each cycle.
4. D write 0x8000_0004 data 0xCAFFE000 in data phase while D issues next read and I wins → pend_v=1, hreadyd=1, pending read issued next cycle; slave write captures 0xCAFFE000.
5. Slave hready=0 for 3 cycles during D data phase with I requesting → haddr/htrans stable, hreadyi=hreadyd=0, no pending capture; resumes correctly.
6. Assert rst_n=0 while pend_v=1 → pend_v=0, dph_own=NONE, htrans=00 with no requests immediately, without waiting for a clock edge.
